// File: rtl/pwm_pkg.sv
// Shared state encoding and sizing helpers for the PWM compare stage.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 11;

  // Compare value that keeps the output high for the whole counter period.
  function automatic int unsigned duty_max(input int unsigned cnt_w);
    return 32'd1 << cnt_w;
  endfunction

endpackage

// File: rtl/deadband_gen.sv
// Dead-time generator: delays each rising edge of hi/lo by DEADTIME clocks.
// Only compiled when PWM_COMPLEMENT_EN is defined.
`ifdef PWM_COMPLEMENT_EN
module deadband_gen #(
  parameter int DEADTIME = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic hi,
  output logic lo
);

  localparam int RW = $clog2(DEADTIME + 2);
  localparam logic [RW-1:0] RUN_MAX = RW'(DEADTIME);

  logic          raw_q;
  logic [RW-1:0] run_q;
  logic [RW-1:0] run_d;

  // run_q counts how long raw has held its level, saturating at DEADTIME.
  always_comb begin
    run_d = run_q;
    if (raw != raw_q) begin
      run_d = '0;
    end else if (run_q != RUN_MAX) begin
      run_d = run_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q <= 1'b0;
      run_q <= '0;
    end else begin
      raw_q <= raw;
      run_q <= run_d;
    end
  end

  assign hi = raw_q && (run_q == RUN_MAX);
  assign lo = !raw_q && (run_q == RUN_MAX);

endmodule
`endif

// File: rtl/pwm_cmp.sv
// PWM compare stage: duty accepted into a shadow register, applied only at count wraps.
// Define PWM_COMPLEMENT_EN to add the dead-time complementary output pwm_n.
module pwm_cmp
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
`ifdef PWM_COMPLEMENT_EN
  , parameter int DEADTIME = 4
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W:0] duty,
  input  logic           duty_valid,
  output logic           duty_ready,
  output logic           pwm,
  output logic           pwm_n,
  output logic           period_tick,
  output logic [CNT_W:0] active_duty,
  output state_t         dbg_state
);

  localparam int unsigned DMAX_I = duty_max(CNT_W);
  localparam logic [CNT_W:0] DMAX = DMAX_I[CNT_W:0];

  logic [CNT_W-1:0] cnt_q;
  state_t           state_q, state_d;
  logic [CNT_W:0]   shadow_q, shadow_d;
  logic [CNT_W:0]   active_q, active_d;
  logic             tick_q;
  logic             pwm_raw_q, pwm_raw_d;
  logic             wrap;
  logic             xfer;
  logic [CNT_W:0]   duty_sat;

  // Any backwards step of the count is a period boundary.
  assign wrap = (cnt < cnt_q);

  // Handshake: duty transfers on a clock where duty_valid && duty_ready; ready is low
  // only while the shadow holds a value that has not yet been applied.
  assign duty_ready = (state_q != PEND);
  assign xfer       = duty_valid && duty_ready;
  assign duty_sat   = (duty > DMAX) ? DMAX : duty;

  // A transfer coinciding with a wrap wins: the new duty waits for the next wrap.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    if (xfer) begin
      shadow_d = duty_sat;
      state_d  = PEND;
    end else if (wrap && (state_q == PEND)) begin
      active_d = shadow_q;
      state_d  = RUN;
    end
  end

  assign pwm_raw_d = (state_q != IDLE) && ({1'b0, cnt} < active_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      state_q   <= IDLE;
      shadow_q  <= '0;
      active_q  <= '0;
      tick_q    <= 1'b0;
      pwm_raw_q <= 1'b0;
    end else begin
      cnt_q     <= cnt;
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      tick_q    <= wrap;
      pwm_raw_q <= pwm_raw_d;
    end
  end

  assign period_tick = tick_q;
  assign active_duty = active_q;
  assign dbg_state   = state_q;

`ifdef PWM_COMPLEMENT_EN
  deadband_gen #(
    .DEADTIME(DEADTIME)
  ) u_deadband (
    .clk(clk),
    .rst(rst),
    .raw(pwm_raw_q),
    .hi (pwm),
    .lo (pwm_n)
  );
`else
  assign pwm   = pwm_raw_q;
  assign pwm_n = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_cmp.sv
// Self-checking bench for pwm_cmp: table-driven duty vectors plus wrap/handshake/reset corners.
`timescale 10ns/1ns
module tb_pwm_cmp;
  import pwm_pkg::*;

  localparam int CNT_W  = 11;
  localparam int W      = CNT_W + 1;
  localparam int PERIOD = 2048;
  localparam int DT     = 4;
  localparam int BOUND  = 5000;
  localparam int NVEC   = 7;

  typedef struct {
    logic [W-1:0] duty;
    logic [W-1:0] exp_active;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] ctr_q = '0;
  logic [W-1:0]     duty;
  logic             duty_valid;
  logic             duty_ready;
  logic             pwm;
  logic             pwm_n;
  logic             period_tick;
  logic [W-1:0]     active_duty;
  state_t           dbg_state;

  logic [W-1:0] exp_q[$];
  vec_t         vecs[NVEC];
  int           checks = 0;
  int           errors = 0;
  int           cur_duty = 0;

  // ---------------- clock / counter / reset ----------------
  always #1 clk = ~clk;
  always @(posedge clk) ctr_q <= ctr_q + 1'b1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  pwm_cmp dut (
    .clk(clk),
    .rst(rst),
    .cnt(ctr_q),
    .duty(duty),
    .duty_valid(duty_valid),
    .duty_ready(duty_ready),
    .pwm(pwm),
    .pwm_n(pwm_n),
    .period_tick(period_tick),
    .active_duty(active_duty),
    .dbg_state(dbg_state)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no DUT event within %0d clks", name, BOUND);
  endtask

  function automatic int exp_hi(input int d);
`ifdef PWM_COMPLEMENT_EN
    if (d >= PERIOD) return PERIOD;
    return (d > DT) ? d - DT : 0;
`else
    return d;
`endif
  endfunction

  function automatic int exp_lo(input int d);
`ifdef PWM_COMPLEMENT_EN
    if (d == 0) return PERIOD;
    return (PERIOD - d > DT) ? PERIOD - d - DT : 0;
`else
    return (d < 0) ? 1 : 0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_cnt(input int value);
    int n = 0;
    while (int'(ctr_q) != value && n < BOUND) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_tick(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < BOUND);
    if (!period_tick) fail_bound({name, "_tick"});
  endtask

  // Presents duty until accepted; returns on the negedge after the transfer clock.
  task automatic send_duty(input logic [W-1:0] d, input logic [W-1:0] exp_sat, input string name);
    int n = 0;
    duty       = d;
    duty_valid = 1'b1;
    while (!duty_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!duty_ready) fail_bound({name, "_accept"});
    exp_q.push_back(exp_sat);
    @(negedge clk);
    duty_valid = 1'b0;
    check({name, "_ready_drop"}, int'(duty_ready), 0);
    check({name, "_state_pend"}, int'(dbg_state), int'(PEND));
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_applied(input string name);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard queue empty, got %0d", name, active_duty);
      return;
    end
    e = exp_q.pop_front();
    cur_duty = int'(e);
    check({name, "_active"}, int'(active_duty), int'(e));
  endtask

  // Starts on a negedge where period_tick is high, ends on the next such negedge.
  task automatic check_period(input string name);
    int hi = 0;
    int lo = 0;
    int both = 0;
    int len = 0;
    do begin
      hi   += int'(pwm);
      lo   += int'(pwm_n);
      both += int'(pwm && pwm_n);
      len++;
      @(negedge clk);
    end while (!period_tick && len < BOUND);
    check({name, "_len"}, len, PERIOD);
    check({name, "_pwm_hi"}, hi, exp_hi(cur_duty));
    check({name, "_pwm_n_hi"}, lo, exp_lo(cur_duty));
    check({name, "_overlap"}, both, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int rdy_hi;
    vecs[0] = '{duty: 12'd512,  exp_active: 12'd512};
    vecs[1] = '{duty: 12'd0,    exp_active: 12'd0};
    vecs[2] = '{duty: 12'd2048, exp_active: 12'd2048};
    vecs[3] = '{duty: 12'd3000, exp_active: 12'd2048};
    vecs[4] = '{duty: 12'd1,    exp_active: 12'd1};
    vecs[5] = '{duty: 12'd2047, exp_active: 12'd2047};
    vecs[6] = '{duty: 12'd1500, exp_active: 12'd1500};

    rst        = 1'b1;
    duty       = '0;
    duty_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(pwm), 0);
    check("rst_pwm_n", int'(pwm_n), 0);
    check("rst_tick", int'(period_tick), 0);
    check("rst_active", int'(active_duty), 0);
    check("rst_ready", int'(duty_ready), 1);
    check("rst_state", int'(dbg_state), int'(IDLE));
    rst = 1'b0;

    // Table: each duty is applied at the next wrap and measured over a later full period.
    for (int i = 0; i < NVEC; i++) begin
      string nm;
      nm = $sformatf("vec%0d_d%0d", i, vecs[i].duty);
      send_duty(vecs[i].duty, vecs[i].exp_active, nm);
      wait_tick(nm);
      check_applied(nm);
      check({nm, "_ready_back"}, int'(duty_ready), 1);
      check({nm, "_state_run"}, int'(dbg_state), int'(RUN));
      wait_tick(nm);
      check_period(nm);
    end

    // Transfer on the exact wrap clock: current period keeps 1500, 100 lands one wrap later.
    wait_cnt(0);
    send_duty(12'd100, 12'd100, "wrap_xfer");
    check("wrap_xfer_tick", int'(period_tick), 1);
    check("wrap_xfer_active_kept", int'(active_duty), 1500);
    check_period("wrap_xfer_cur");
    check_applied("wrap_xfer_next");
    check_period("wrap_xfer_new");

    // Valid held through PEND: 300 accepted, 700 waits for the wrap.
    wait_cnt(1000);
    duty       = 12'd300;
    duty_valid = 1'b1;
    exp_q.push_back(12'd300);
    @(negedge clk);
    check("hold_300_ready_drop", int'(duty_ready), 0);
    duty = 12'd700;
    exp_q.push_back(12'd700);
    n      = 0;
    rdy_hi = 0;
    while (!period_tick && n < BOUND) begin
      @(negedge clk);
      n++;
      if (duty_ready && !period_tick) rdy_hi++;
    end
    if (!period_tick) fail_bound("hold_tick");
    check("hold_ready_low_in_pend", rdy_hi, 0);
    check_applied("hold_300");
    check("hold_ready_back", int'(duty_ready), 1);
    @(negedge clk);
    duty_valid = 1'b0;
    check("hold_700_ready_drop", int'(duty_ready), 0);
    check("hold_700_not_yet", int'(active_duty), 300);
    wait_tick("hold_700");
    check_applied("hold_700");
    wait_tick("hold_700");
    check_period("hold_700");

    // Reset mid-period while pwm is high.
    wait_cnt(200);
    check("midrst_pwm_before", int'(pwm), 1);
    rst = 1'b1;
    #0.5;
    check("midrst_pwm", int'(pwm), 0);
    check("midrst_pwm_n", int'(pwm_n), 0);
    check("midrst_ready", int'(duty_ready), 1);
    check("midrst_active", int'(active_duty), 0);
    check("midrst_tick", int'(period_tick), 0);
    check("midrst_state", int'(dbg_state), int'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    wait_tick("post_rst");
    cur_duty = 0;
    check("post_rst_active", int'(active_duty), 0);
    check("post_rst_state", int'(dbg_state), int'(IDLE));
    check_period("post_rst");

    check("sb_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
